fifo_param: RTL and testbench

Parametrised synchronous FIFO; next generation of the team's fixed 32x8 FIFO. Generalised in data width and depth, selectable normal or show-ahead read mode, programmable almost-full/almost-empty flags, full-range occupancy count and sticky overflow/underflow error flags. Sits between producer and consumer logic in one clock domain and is a drop-in replacement for the 32x8 part when `WIDTH=8`, `DEPTH=32`, `MODE=FIFO_NORMAL`.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_ram.sv | 26 ++
 rtl/fifo_param.sv | 135 +++++++++++++
 tb/tb_fifo_param.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the parametrised FIFO family.
package fifo_pkg;

    typedef enum logic {
        FIFO_NORMAL     = 1'b0,
        FIFO_SHOW_AHEAD = 1'b1
    } fifo_mode_e;

    localparam int FIFO_MIN_DEPTH = 4;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for fifo_param: synchronous write, combinational read.
module fifo_ram #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the pointers and count define which words are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with normal/show-ahead read, programmable
// almost flags, full-range occupancy and sticky overflow/underflow bits.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int         WIDTH    = 8,
    parameter int         DEPTH    = 32,
    parameter int         AF_LEVEL = DEPTH - 4,
    parameter int         AE_LEVEL = 4,
    parameter fifo_mode_e MODE     = FIFO_NORMAL,
    localparam int        AW       = $clog2(DEPTH),
    localparam int        CW       = AW + 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             CLEAR_N,
    input  logic             WRITE,
    input  logic             READ,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             F_FULL_N,
    output logic             F_EMPTY_N,
    output logic             F_AFULL_N,
    output logic             F_AEMPTY_N,
    output logic [CW-1:0]    USE_DW,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_chk_pow2
        $error("fifo_param: DEPTH must be a power of two");
    end
    if (DEPTH < FIFO_MIN_DEPTH) begin : g_chk_min
        $error("fifo_param: DEPTH below FIFO_MIN_DEPTH");
    end
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_chk_levels
        $error("fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_THR   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_THR   = CW'(AE_LEVEL);

    logic [AW-1:0]    rd_ptr, rd_ptr_nxt;
    logic [AW-1:0]    wr_ptr, wr_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] dout_q, dout_nxt;
    logic [WIDTH-1:0] ram_rd_data;
    logic             ovf_nxt, unf_nxt;
    logic             rd_ok, wr_ok;

    // A write into a full FIFO still lands when a read frees the head slot on the same edge.
    assign rd_ok = READ && F_EMPTY_N;
    assign wr_ok = WRITE && (F_FULL_N || rd_ok);

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (CLOCK),
        .wr_en   (wr_ok && CLEAR_N),
        .wr_addr (wr_ptr),
        .wr_data (DATA_IN),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = USE_DW;
        dout_nxt   = dout_q;
        ovf_nxt    = OVERFLOW;
        unf_nxt    = UNDERFLOW;
        if (!CLEAR_N) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
            dout_nxt   = '0;
            ovf_nxt    = 1'b0;
            unf_nxt    = 1'b0;
        end else begin
            if (rd_ok) begin
                rd_ptr_nxt = rd_ptr + AW'(1);
                dout_nxt   = ram_rd_data;
            end
            if (wr_ok) begin
                wr_ptr_nxt = wr_ptr + AW'(1);
            end
            if (wr_ok && !rd_ok) begin
                count_nxt = USE_DW + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count_nxt = USE_DW - CW'(1);
            end
            if (WRITE && !wr_ok) begin
                ovf_nxt = 1'b1;
            end
            if (READ && !rd_ok) begin
                unf_nxt = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            USE_DW     <= '0;
            dout_q     <= '0;
            OVERFLOW   <= 1'b0;
            UNDERFLOW  <= 1'b0;
            F_FULL_N   <= 1'b1;
            F_EMPTY_N  <= 1'b0;
            F_AFULL_N  <= 1'b1;
            F_AEMPTY_N <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= wr_ptr_nxt;
            USE_DW     <= count_nxt;
            dout_q     <= dout_nxt;
            OVERFLOW   <= ovf_nxt;
            UNDERFLOW  <= unf_nxt;
            F_FULL_N   <= (count_nxt != FULL_CNT);
            F_EMPTY_N  <= (count_nxt != '0);
            F_AFULL_N  <= !(count_nxt >= AF_THR);
            F_AEMPTY_N <= !(count_nxt <= AE_THR);
        end
    end

    // Show-ahead presents the head word directly; it reads as zero while empty.
    assign DATA_OUT = (MODE == FIFO_SHOW_AHEAD) ? (F_EMPTY_N ? ram_rd_data : '0) : dout_q;

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: one normal-mode and one show-ahead instance share
// the same randomised stimulus and are compared against a queue-based reference model.
module tb_fifo_param;
    import fifo_pkg::*;

    localparam int DEPTH = 32;
    localparam int AF    = DEPTH - 4;
    localparam int AE    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset, clear_n, write, read;
    logic [7:0]    data_in;

    logic [7:0]    n_dout, s_dout;
    logic          n_full_n, n_empty_n, n_afull_n, n_aempty_n, n_ovf, n_unf;
    logic          s_full_n, s_empty_n, s_afull_n, s_aempty_n, s_ovf, s_unf;
    logic [CW-1:0] n_use_dw, s_use_dw;

    always #5 clock = ~clock;

    fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .MODE(FIFO_NORMAL)) dut_n (
        .CLOCK(clock), .RESET(reset), .CLEAR_N(clear_n), .WRITE(write), .READ(read),
        .DATA_IN(data_in), .DATA_OUT(n_dout), .F_FULL_N(n_full_n), .F_EMPTY_N(n_empty_n),
        .F_AFULL_N(n_afull_n), .F_AEMPTY_N(n_aempty_n), .USE_DW(n_use_dw),
        .OVERFLOW(n_ovf), .UNDERFLOW(n_unf)
    );

    fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .MODE(FIFO_SHOW_AHEAD)) dut_s (
        .CLOCK(clock), .RESET(reset), .CLEAR_N(clear_n), .WRITE(write), .READ(read),
        .DATA_IN(data_in), .DATA_OUT(s_dout), .F_FULL_N(s_full_n), .F_EMPTY_N(s_empty_n),
        .F_AFULL_N(s_afull_n), .F_AEMPTY_N(s_aempty_n), .USE_DW(s_use_dw),
        .OVERFLOW(s_ovf), .UNDERFLOW(s_unf)
    );

    typedef struct {
        int       cyc;
        int       cnt;
        bit       ovf;
        bit       unf;
        bit [7:0] dn;
        bit [7:0] ds;
    } exp_t;

    exp_t     exp_q[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc    = 0;

    // Reference model: the FIFO contents as a queue plus the observable sticky state.
    bit [7:0] mq[$];
    bit       m_ovf, m_unf;
    bit [7:0] m_dn;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_dn  = 8'h00;
    endfunction

    function automatic void push_exp(input int at);
        exp_t e;
        e.cyc = at;
        e.cnt = mq.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        e.dn  = m_dn;
        e.ds  = (mq.size() > 0) ? mq[0] : 8'h00;
        exp_q.push_back(e);
    endfunction

    // Drive one cycle of requests and record what the FIFO must look like after that edge.
    task automatic step(input bit wr, input bit rd, input logic [7:0] din, input bit clr_n = 1'b1);
        bit rd_ok, wr_ok;
        @(posedge clock);
        #1;
        write   = wr;
        read    = rd;
        data_in = din;
        clear_n = clr_n;
        if (!clr_n) begin
            model_reset();
        end else begin
            rd_ok = rd && (mq.size() > 0);
            wr_ok = wr && ((mq.size() < DEPTH) || rd_ok);
            if (rd && !rd_ok) m_unf = 1'b1;
            if (wr && !wr_ok) m_ovf = 1'b1;
            if (rd_ok) m_dn = mq.pop_front();
            if (wr_ok) mq.push_back(din);
        end
        push_exp(cyc + 1);
    endtask

    // Assert RESET between edges and confirm the outputs react before any clock edge.
    task automatic pulse_reset();
        @(posedge clock);
        #1;
        write   = 1'b0;
        read    = 1'b0;
        clear_n = 1'b1;
        #2;
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        check("rst_async_use_dw",  n_use_dw,  0);
        check("rst_async_empty_n", n_empty_n, 0);
        check("rst_async_full_n",  n_full_n,  1);
        check("rst_async_aempty",  s_aempty_n, 0);
        check("rst_async_dout_s",  s_dout,    0);
        push_exp(cyc);
        @(posedge clock);
        #1;
        reset = 1'b0;
        push_exp(cyc);
    endtask

    // Monitor: pop every expectation due at this sample point and compare both instances.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("sample_cycle", cyc, e.cyc);
                check("use_dw_n",   n_use_dw,   e.cnt);
                check("use_dw_s",   s_use_dw,   e.cnt);
                check("full_n",     n_full_n,   e.cnt != DEPTH);
                check("empty_n",    n_empty_n,  e.cnt != 0);
                check("empty_n_s",  s_empty_n,  e.cnt != 0);
                check("afull_n",    n_afull_n,  !(e.cnt >= AF));
                check("aempty_n",   n_aempty_n, !(e.cnt <= AE));
                check("overflow",   n_ovf,      e.ovf);
                check("underflow",  n_unf,      e.unf);
                check("overflow_s", s_ovf,      e.ovf);
                check("dout_norm",  n_dout,     e.dn);
                check("dout_show",  s_dout,     e.ds);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pw, pr;
        reset   = 1'b1;
        clear_n = 1'b1;
        write   = 1'b0;
        read    = 1'b0;
        data_in = 8'h00;
        model_reset();
        pulse_reset();

        // Fill past full, then drain past empty.
        for (int i = 1; i <= 33; i++) step(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 33; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Two 20-word bursts so the pointers wrap past DEPTH.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'(32'h40 + i));
            for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00);
        end

        // Simultaneous read+write on full, then on empty.
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 4; i++)  step(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h77);

        // Clear with ten words stored and a write pending, then show-ahead first word.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b0, 8'h99, 1'b0);
        step(1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Randomised traffic in phases biased toward full, toward empty, and balanced.
        for (int i = 0; i < 450; i++) begin
            pw = (i < 150) ? 75 : (i < 300) ? 25 : 50;
            pr = 100 - pw;
            if (i == 320) begin
                for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'($urandom));
                pulse_reset();
            end
            step($urandom_range(99) < pw, $urandom_range(99) < pr, 8'($urandom),
                 $urandom_range(99) != 0);
        end
        step(1'b0, 1'b0, 8'h00);

        repeat (3) @(posedge clock);
        check("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
